// File: rtl/iob_except_pkg.sv
// Shared definitions for the IOB exception-record bank.
// Holds the default geometry (lanes, rows, write ports), the default record
// width and the {row, lane} write-address packing helper used by every
// producer that drives a lane write port.
`ifndef IOB_EXCEPT_WIDTH
`define IOB_EXCEPT_WIDTH 16
`endif

package iob_except_pkg;

  localparam int EXCEPT_WIDTH   = `IOB_EXCEPT_WIDTH;
  localparam int DEF_LANES      = 10;
  localparam int DEF_ROWS       = 48;
  localparam int DEF_WPORTS     = 9;
  localparam int DEF_ROW_BITS   = $clog2(DEF_ROWS);
  localparam int DEF_LANE_BITS  = $clog2(DEF_LANES);
  localparam int DEF_WADDR_BITS = DEF_ROW_BITS + DEF_LANE_BITS;

  // Lane write address: row in the upper bits, lane in the lower bits.
  function automatic logic [DEF_WADDR_BITS-1:0] pack_waddr(
    input logic [DEF_ROW_BITS-1:0]  row,
    input logic [DEF_LANE_BITS-1:0] lane
  );
    return {row, lane};
  endfunction

endpackage

// File: rtl/iob_except_lane.sv
// One lane (column) of the exception bank: ROWS records plus valid/pending.
// Ports:
//   clk, rst_n            clock, async active-low reset (valid/pending only)
//   wr_*                  all lane write ports; only those addressing LANE_IDX apply
//   init_*                whole-row init slice for this lane
//   clr_en, clr_addr      row retire
//   rd_row                registered read row from the top level
//   rd_data/valid/pend    combinational view of entry rd_row
//   wr_err                a winning write hit an entry whose valid bit is 0
module iob_except_lane
  import iob_except_pkg::*;
#(
  parameter int DATA_WIDTH = EXCEPT_WIDTH,
  parameter int ROWS       = DEF_ROWS,
  parameter int WPORTS     = DEF_WPORTS,
  parameter int ROW_BITS   = $clog2(ROWS),
  parameter int LANE_BITS  = DEF_LANE_BITS,
  parameter int LANE_IDX   = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [WPORTS-1:0]                      wr_en,
  input  logic [WPORTS*(ROW_BITS+LANE_BITS)-1:0] wr_addr,
  input  logic [WPORTS*DATA_WIDTH-1:0]           wr_data,
  input  logic [WPORTS-1:0]                      wr_pend,
  input  logic                                   init_en,
  input  logic [ROW_BITS-1:0]                    init_addr,
  input  logic [DATA_WIDTH-1:0]                  init_data,
  input  logic                                   init_valid,
  input  logic                                   clr_en,
  input  logic [ROW_BITS-1:0]                    clr_addr,
  input  logic [ROW_BITS-1:0]                    rd_row,
  output logic [DATA_WIDTH-1:0]                  rd_data,
  output logic                                   rd_valid,
  output logic                                   rd_pend,
  output logic                                   wr_err
);

  localparam int                 AW      = ROW_BITS + LANE_BITS;
  localparam logic [ROW_BITS:0]  ROWS_L  = (ROW_BITS+1)'(ROWS);
  localparam logic [LANE_BITS-1:0] MY_LANE = LANE_BITS'(LANE_IDX);

  logic [DATA_WIDTH-1:0] data_q [ROWS];
  logic [DATA_WIDTH-1:0] data_d [ROWS];
  logic [ROWS-1:0]       valid_q, valid_d;
  logic [ROWS-1:0]       pend_q, pend_d;

  logic [ROW_BITS-1:0]   prow [WPORTS];
  logic [WPORTS-1:0]     hit;
  logic [WPORTS-1:0]     win;
  logic                  init_ok, clr_ok;

  assign init_ok = init_en && ({1'b0, init_addr} < ROWS_L);
  assign clr_ok  = clr_en  && ({1'b0, clr_addr}  < ROWS_L);

  // A port wins its entry only if no init, no clear and no higher-numbered
  // port targets the same row of this lane in the same cycle.
  always_comb begin
    hit = '0;
    win = '0;
    for (int p = 0; p < WPORTS; p++) begin
      prow[p] = wr_addr[p*AW+LANE_BITS +: ROW_BITS];
      hit[p]  = wr_en[p] && (wr_addr[p*AW +: LANE_BITS] == MY_LANE) &&
                ({1'b0, prow[p]} < ROWS_L);
    end
    for (int p = 0; p < WPORTS; p++) begin
      win[p] = hit[p] && !(init_ok && init_addr == prow[p]) &&
               !(clr_ok && clr_addr == prow[p]);
      for (int q = p + 1; q < WPORTS; q++) begin
        if (hit[q] && prow[q] == prow[p]) win[p] = 1'b0;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    wr_err  = 1'b0;
    for (int p = 0; p < WPORTS; p++) begin
      if (win[p]) begin
        data_d[prow[p]] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        pend_d[prow[p]] = wr_pend[p];
        if (!valid_q[prow[p]]) wr_err = 1'b1;
      end
    end
    if (clr_ok) begin
      valid_d[clr_addr] = 1'b0;
      pend_d[clr_addr]  = 1'b0;
    end
    if (init_ok) begin
      data_d[init_addr]  = init_data;
      valid_d[init_addr] = init_valid;
      pend_d[init_addr]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      pend_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  // Data is not reset, but writes in a cycle where reset is held are aborted.
  always_ff @(posedge clk) begin
    if (rst_n) data_q <= data_d;
  end

  // Out-of-range rd_row is masked at the top level.
  assign rd_data  = data_q[rd_row];
  assign rd_valid = valid_q[rd_row];
  assign rd_pend  = pend_q[rd_row];

endmodule

// File: rtl/iob_except_bank.sv
// Exception-record bank for the instruction-ordering buffer: ROWS x LANES
// entries of {data, valid, pending}.
// Ports:
//   clk, rst                    clock, async active-low reset
//   read_step, read_addr        load the read row register
//   rd_data/rd_pend/rd_any/rd_first  combinational view of the registered row
//   wr_en/wr_addr/wr_data/wr_pend    WPORTS lane write ports, address {row, lane}
//   init_en/addr/data/mask     whole-row init
//   clr_en/clr_addr            row retire
//   err                        sticky protocol error
// Interface rule: there is no valid/ready handshake anywhere; every write
// port, init, clear and read_step presented in a cycle is accepted in that
// cycle, and results appear on the outputs from the next cycle.
module iob_except_bank
  import iob_except_pkg::*;
#(
  parameter int DATA_WIDTH = EXCEPT_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ROWS       = DEF_ROWS,
  parameter int WPORTS     = DEF_WPORTS,
  parameter int ROW_BITS   = $clog2(ROWS),
  parameter int LANE_BITS  = $clog2(LANES)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   read_step,
  input  logic [ROW_BITS-1:0]                    read_addr,
  output logic [LANES*DATA_WIDTH-1:0]            rd_data,
  output logic [LANES-1:0]                       rd_pend,
  output logic                                   rd_any,
  output logic [LANE_BITS-1:0]                   rd_first,
  input  logic [WPORTS-1:0]                      wr_en,
  input  logic [WPORTS*(ROW_BITS+LANE_BITS)-1:0] wr_addr,
  input  logic [WPORTS*DATA_WIDTH-1:0]           wr_data,
  input  logic [WPORTS-1:0]                      wr_pend,
  input  logic                                   init_en,
  input  logic [ROW_BITS-1:0]                    init_addr,
  input  logic [LANES*DATA_WIDTH-1:0]            init_data,
  input  logic [LANES-1:0]                       init_mask,
  input  logic                                   clr_en,
  input  logic [ROW_BITS-1:0]                    clr_addr,
  output logic                                   err
);

  localparam int                   AW      = ROW_BITS + LANE_BITS;
  localparam logic [ROW_BITS:0]    ROWS_L  = (ROW_BITS+1)'(ROWS);
  localparam logic [LANE_BITS:0]   LANES_L = (LANE_BITS+1)'(LANES);

  logic [ROW_BITS-1:0]         rd_row_q, rd_row_d;
  logic                        err_q, err_d;
  logic                        rd_bad;
  logic                        bad_wr;
  logic [LANES-1:0]            lane_err, lane_valid, lane_pend;
  logic [LANES*DATA_WIDTH-1:0] lane_data;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    iob_except_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROWS       (ROWS),
      .WPORTS     (WPORTS),
      .ROW_BITS   (ROW_BITS),
      .LANE_BITS  (LANE_BITS),
      .LANE_IDX   (k)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_pend    (wr_pend),
      .init_en    (init_en),
      .init_addr  (init_addr),
      .init_data  (init_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .init_valid (init_mask[k]),
      .clr_en     (clr_en),
      .clr_addr   (clr_addr),
      .rd_row     (rd_row_q),
      .rd_data    (lane_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid   (lane_valid[k]),
      .rd_pend    (lane_pend[k]),
      .wr_err     (lane_err[k])
    );
  end

  // An out-of-range row is still loaded so that the outputs go to zero.
  assign rd_bad = !({1'b0, rd_row_q} < ROWS_L);

  always_comb begin
    rd_row_d = rd_row_q;
    if (read_step) rd_row_d = read_addr;
    bad_wr = 1'b0;
    for (int p = 0; p < WPORTS; p++) begin
      if (wr_en[p] && (!({1'b0, wr_addr[p*AW +: LANE_BITS]} < LANES_L) ||
                       !({1'b0, wr_addr[p*AW+LANE_BITS +: ROW_BITS]} < ROWS_L)))
        bad_wr = 1'b1;
    end
    err_d = err_q || (|lane_err) || bad_wr ||
            (init_en   && !({1'b0, init_addr} < ROWS_L)) ||
            (read_step && !({1'b0, read_addr} < ROWS_L));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_row_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_row_q <= rd_row_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    rd_data  = rd_bad ? '0 : lane_data;
    rd_pend  = rd_bad ? '0 : (lane_valid & lane_pend);
    rd_any   = |rd_pend;
    rd_first = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (rd_pend[k]) rd_first = LANE_BITS'(k);
    end
  end

  assign err = err_q;

endmodule
